// File: rtl/eth_pkt_fifo_reader.sv
// Drains a show-ahead FIFO into fixed-length packets for the UDP TX engine,
// padding on underrun and holding an inter-packet gap after each packet.
module eth_pkt_fifo_reader #(
   parameter int unsigned PKT_WORDS  = 256,
   parameter int unsigned IFG_CYCLES = 64,
   parameter logic [31:0] PAD_WORD   = 32'h0000_0000
) (
   input  logic        rd_clk,
   input  logic        rd_rst,
   input  logic        en,
   input  logic        rd_vld,
   input  logic [31:0] rd_data,
   output logic        rd_en,
   output logic        tx_start_en,
   output logic [15:0] tx_byte_num,
   input  logic        tx_req,
   output logic [31:0] tx_data,
   input  logic        tx_done,
   output logic        busy,
   output logic [31:0] pkt_cnt,
   output logic [15:0] underrun_cnt
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      SEND,
      WAIT_DONE,
      GAP
   } state_t;

   localparam logic [13:0] LAST_WORD = 14'(PKT_WORDS - 1);
   localparam logic [15:0] LAST_GAP  = 16'(IFG_CYCLES - 1);
   localparam logic [15:0] BYTE_NUM  = 16'(PKT_WORDS * 4);

   state_t      state;
   state_t      state_nxt;
   logic [13:0] word_cnt;
   logic [15:0] gap_cnt;
   logic        serve;

   assign serve = (state == SEND) & tx_req;

   always_ff @(posedge rd_clk) begin
      if (rd_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (en && rd_vld) state_nxt = START;
         START:     state_nxt = SEND;
         SEND: begin
            // an early tx_done wins over the last-word transition
            if (tx_done)
               state_nxt = GAP;
            else if (tx_req && word_cnt == LAST_WORD)
               state_nxt = WAIT_DONE;
         end
         WAIT_DONE: if (tx_done) state_nxt = GAP;
         GAP:       if (gap_cnt == LAST_GAP) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_start_en = (state == START);
      busy        = (state != IDLE);
      rd_en       = serve & rd_vld & ~rd_rst;
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         tx_byte_num  <= '0;
         tx_data      <= '0;
         pkt_cnt      <= '0;
         underrun_cnt <= '0;
         word_cnt     <= '0;
         gap_cnt      <= '0;
      end else begin
         if (state == START) begin
            tx_byte_num <= BYTE_NUM;
            word_cnt    <= '0;
         end
         if (serve) begin
            word_cnt <= word_cnt + 14'd1;
            tx_data  <= rd_vld ? rd_data : PAD_WORD;
            if (!rd_vld && underrun_cnt != 16'hFFFF)
               underrun_cnt <= underrun_cnt + 16'd1;
         end
         if (state == WAIT_DONE && tx_done)
            pkt_cnt <= pkt_cnt + 32'd1;
         gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
      end
   end

endmodule

// File: doc/eth_pkt_fifo_reader.md
Name: eth_pkt_fifo_reader

Overview:
- Read-side companion of the 32-bit Ethernet packet prefetch FIFO.
- Drains words from the FIFO's show-ahead read port (rd_vld/rd_en/rd_data).
- Frames them into fixed-length packets for the UDP transmit engine using its start/request/done handshake (tx_start_en, tx_req, tx_data, tx_done).
- Lives entirely in the FIFO read clock domain.
- Handles FIFO underrun by padding, and enforces an inter-packet gap.

Parameters:
- PKT_WORDS, 256, 32-bit words per packet; legal 1..16383; tx_byte_num = PKT_WORDS*4.
- IFG_CYCLES, 64, idle cycles after each packet before the next may start; legal 1..65535.
- PAD_WORD, 32'h0000_0000, word sent on tx_req when the FIFO is empty (underrun).

Ports:
- rd_clk, input, 1, FIFO read-side clock; the only clock.
- rd_rst, input, 1, reset; synchronous to rd_clk and active-high.
- en, input, 1, packet generation enable; sampled only in IDLE.
- rd_vld, input, 1, FIFO head word valid (show-ahead).
- rd_data, input, 32, FIFO head word.
- rd_en, output, 1, pop FIFO head; combinational.
- tx_start_en, output, 1, one-cycle packet start pulse to the UDP TX engine.
- tx_byte_num, output, 16, packet payload length in bytes.
- tx_req, input, 1, UDP TX request for the next word; one pulse per word.
- tx_data, output, 32, word for UDP TX; valid from the cycle after tx_req.
- tx_done, input, 1, UDP TX packet complete pulse.
- busy, output, 1, high in every state except IDLE.
- pkt_cnt, output, 32, packets completed; wraps.
- underrun_cnt, output, 16, padded words sent; saturates at 16'hFFFF.

Behaviour:
Reset (rd_rst=1 at a rising edge, any state, including mid-packet):
- State goes to IDLE.
- tx_start_en=0, tx_byte_num=0, tx_data=0, busy=0, pkt_cnt=0, underrun_cnt=0, word_cnt=0, gap_cnt=0.
- rd_en=0 while rd_rst=1.
- No handshake is resumed after reset. An aborted packet is not counted.

FSM states: IDLE, START, SEND, WAIT_DONE, GAP.

IDLE:
- en=1 and rd_vld=1 -> START.
- Otherwise stay. Packets never start on an empty FIFO.

START (exactly one cycle):
- tx_start_en=1.
- tx_byte_num <= PKT_WORDS*4; held until the next START.
- word_cnt <= 0.
- -> SEND.

SEND:
- rd_en = tx_req & rd_vld (combinational; only asserted in SEND).
- On tx_req with rd_vld=1: tx_data <= rd_data; the head word is popped the same cycle.
- On tx_req with rd_vld=0: tx_data <= PAD_WORD; no pop; underrun_cnt +1 (saturating).
- Each tx_req increments word_cnt. When the request served is number PKT_WORDS (word_cnt == PKT_WORDS-1 at tx_req) -> WAIT_DONE.
- tx_done in SEND: early termination -> GAP; pkt_cnt is not incremented.

WAIT_DONE:
- Extra tx_req is ignored: no pop, tx_data holds, no counter change.
- tx_done -> pkt_cnt+1 and -> GAP.

GAP:
- gap_cnt counts 0..IFG_CYCLES-1, then -> IDLE.
- tx_req and tx_done are ignored.

General rules:
- tx_data changes only on a served tx_req.
- en is ignored outside IDLE. Deasserting en mid-packet lets the current packet finish.
- Simultaneous tx_req and tx_done in SEND: the word is served (pop/pad applies) and tx_done takes precedence for the transition -> GAP.
- Back-to-back tx_req on consecutive cycles is supported at one word per cycle. Throughput depends only on the FIFO sustaining rd_vld after a pop.

Test Plan:
- PKT_WORDS=4, IFG_CYCLES=3. FIFO preloaded with 1,2,3,4; en=1; tx_req every 2 cycles; tx_done 5 cycles after the 4th request.
  -> tx_start_en is a single pulse; tx_byte_num=16; tx_data sequence 1,2,3,4; rd_en pulses 4 times, each coincident with tx_req; pkt_cnt=1; busy falls exactly 3 cycles after tx_done.
- Underrun: FIFO holds only 11,22; PKT_WORDS=4.
  -> tx_data sequence 11,22,0,0; rd_en pulses 2 times; underrun_cnt=2; pkt_cnt=1 after tx_done.
- en=1 with an empty FIFO for 100 cycles.
  -> tx_start_en never asserts; busy=0. Then push one word -> START occurs 1 cycle after rd_vld rises.
- rd_rst asserted after the 2nd tx_req of a 4-word packet.
  -> Next cycle: all outputs are at reset values, pkt_cnt=0, and a new packet starts cleanly once rd_vld=1.
- Early tx_done after 2 words, with a simultaneous tx_req on the 2nd word.
  -> The word is served, state goes to GAP, pkt_cnt is unchanged, and no further pops occur.
- Extra tx_req in WAIT_DONE, then en dropped during GAP.
  -> No pop and tx_data holds; after GAP the FSM stays in IDLE even with rd_vld=1.
